// File: rtl/gp0_cmd_fifo_pkg.sv
// Shared types and constants for the GP0 command FIFO and its packet-length decoder.
package gp0_cmd_fifo_pkg;

  typedef enum logic [2:0] {
    FS_HEAD,
    FS_PACKET,
    FS_POLY,
    FS_CPY_HDR,
    FS_CPY_DATA
  } fifoState_t;

  localparam logic [31:0] POLY_TERM_MASK  = 32'h5000_5000;
  localparam logic [31:0] POLY_TERM_VALUE = 32'h5000_5000;
  localparam int          GP0_MAX_PACKET  = 12;
  localparam int          LEN_W           = $clog2(GP0_MAX_PACKET + 1);

  typedef logic [LEN_W-1:0] len_t;

endpackage

// File: rtl/gp0_cmd_fifo_length.sv
// Combinational GP0 opcode decoder: packet length in words plus polyline / CPU->VRAM flags.
module gp0_cmd_length
  import gp0_cmd_fifo_pkg::*;
(
  input  logic [7:0] op,
  output len_t       len,
  output logic       is_poly,
  output logic       is_cpy
);

  len_t nv;

  always_comb begin
    len     = len_t'(1);
    is_poly = 1'b0;
    is_cpy  = 1'b0;
    nv      = op[3] ? len_t'(4) : len_t'(3);
    case (op[7:5])
      3'b000: if (op == 8'h02) len = len_t'(3);
      // polygon: op[4]=gouraud, op[3]=quad, op[2]=textured
      3'b001: len = len_t'(1) + (op[2] ? (nv << 1) : nv) + (op[4] ? nv - len_t'(1) : len_t'(0));
      3'b010: begin
        len     = op[4] ? len_t'(4) : len_t'(3);
        is_poly = op[3];
      end
      3'b011: len = len_t'(2) + len_t'(op[2]) + len_t'(op[4:3] == 2'b00);
      3'b100: len = len_t'(4);
      3'b101: begin
        len    = len_t'(3);
        is_cpy = 1'b1;
      end
      3'b110: len = len_t'(3);
      default: len = len_t'(1);
    endcase
  end

endmodule

// File: rtl/gp0_cmd_fifo.sv
// GP0 command FIFO with packet framer: holds cmdReady low until a whole packet is buffered
// and tracks polyline and CPU->VRAM variable-length tails.
module gp0_cmd_fifo
  import gp0_cmd_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  i_nrst,
  input  logic                  i_flush,
  input  logic                  i_wr,
  input  logic [31:0]           i_data,
  output logic                  o_full,
  input  logic                  i_rd,
  output logic [31:0]           o_data,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_cmdReady,
  output logic                  o_dataPhase,
  output logic                  o_isTerminator
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  fifoState_t            state;
  logic [18:0]           rem;
  logic                  poly_pend;

  logic [31:0] head;
  logic        empty, full, do_push, do_pop, is_term;
  len_t        len;
  logic        is_poly, is_cpy;

  logic [9:0]  w_m1;
  logic [8:0]  h_m1;
  logic [20:0] prod;
  logic [18:0] rem_load;

  assign head    = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = i_rd && !empty;
  assign do_push = i_wr && (!full || i_rd);
  assign is_term = (head & POLY_TERM_MASK) == POLY_TERM_VALUE;

  gp0_cmd_length u_len (
    .op      (head[31:24]),
    .len     (len),
    .is_poly (is_poly),
    .is_cpy  (is_cpy)
  );

  // size field 0 wraps to the maximum (1024 x 512)
  assign w_m1     = 10'(head[15:0] - 16'd1);
  assign h_m1     = 9'(head[31:16] - 16'd1);
  assign prod     = (21'(w_m1) + 21'd1) * (21'(h_m1) + 21'd1);
  assign rem_load = 19'((prod + 21'd1) >> 1);

  always_ff @(posedge clk) begin
    if (do_push && !i_flush) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state     <= FS_HEAD;
      rem       <= '0;
      poly_pend <= 1'b0;
    end else if (i_flush) begin
      state     <= FS_HEAD;
      rem       <= '0;
      poly_pend <= 1'b0;
    end else if (do_pop) begin
      case (state)
        FS_HEAD: begin
          rem       <= 19'(len) - 19'd1;
          poly_pend <= 1'b0;
          if (is_cpy) state <= FS_CPY_HDR;
          else if (is_poly) begin
            if (len == len_t'(1)) state <= FS_POLY;
            else begin
              state     <= FS_PACKET;
              poly_pend <= 1'b1;
            end
          end else if (len != len_t'(1)) state <= FS_PACKET;
        end
        FS_PACKET: begin
          rem <= rem - 19'd1;
          if (rem == 19'd1) begin
            state     <= poly_pend ? FS_POLY : FS_HEAD;
            poly_pend <= 1'b0;
          end
        end
        FS_POLY: if (is_term) state <= FS_HEAD;
        FS_CPY_HDR: begin
          if (rem == 19'd1) begin
            rem   <= rem_load;
            state <= FS_CPY_DATA;
          end else rem <= rem - 19'd1;
        end
        FS_CPY_DATA: begin
          rem <= rem - 19'd1;
          if (rem == 19'd1) state <= FS_HEAD;
        end
        default: state <= FS_HEAD;
      endcase
    end
  end

  always_comb begin
    o_cmdReady = 1'b0;
    case (state)
      FS_HEAD: o_cmdReady = !empty && (count >= CNT_W'(len));
      default: o_cmdReady = !empty;
    endcase
  end

  assign o_dataPhase    = (state == FS_CPY_DATA);
  assign o_isTerminator = (state == FS_POLY) && !empty && is_term;
  assign o_data         = empty ? 32'd0 : head;
  assign o_empty        = empty;
  assign o_full         = full;
  assign o_count        = count;

endmodule

// File: doc/gp0_cmd_fifo.md
# gp0_cmd_fifo

Command FIFO and packet framer between the GP0 write port (CPU/DMA) and the GP0 command parser. Buffers 32-bit GP0 words, decodes the length of the command at the FIFO head, and raises `o_cmdReady` only when the parser can consume a whole packet without stalling mid-command. It also tracks the variable-length tails: the polyline stream up to its terminator, and the CPU→VRAM pixel-data stream.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 words (16). Must be ≥4 so that the longest fixed packet (12 words) fits.
- `clk` in 1: system clock.
- `i_nrst` in 1: asynchronous, active-low reset.
- `i_flush` in 1: synchronous GP1(01h) command-buffer reset.
- `i_wr` in 1: push `i_data`.
- `i_data` in 32: GP0 word.
- `o_full` out 1: FIFO holds 2^DEPTH_LOG2 words.
- `i_rd` in 1: parser pops the head word. Ignored when `o_empty`.
- `o_data` out 32: head word, first-word-fall-through; 0 when empty.
- `o_empty` out 1: FIFO holds no words.
- `o_count` out DEPTH_LOG2+1: number of words stored.
- `o_cmdReady` out 1: the current packet, or the next stream word, is available.
- `o_dataPhase` out 1: the head word is CPU→VRAM pixel data.
- `o_isTerminator` out 1: in the polyline phase, the head word is a terminator.

## Operation
- Storage: register array with wrapping read/write pointers of DEPTH_LOG2 bits; the array itself is not reset.
- Push: accepted when `i_wr && (!o_full || i_rd)`; otherwise the word is silently dropped.
- Count: push and pop in the same cycle leave `o_count` unchanged.
- Flush: `i_flush` has priority over `i_wr`/`i_rd`. Pointers, count, state and remaining counter all clear.
- States (`fifoState_t`):
  - `FS_HEAD`: at a packet boundary.
  - `FS_PACKET`: inside a fixed-length packet.
  - `FS_POLY`: inside a polyline stream.
  - `FS_CPY_HDR`: inside the A0h header.
  - `FS_CPY_DATA`: inside the A0h pixel stream.
- Length L(op), where op = head[31:24]:
  - 02h: 3. 01h, 1Fh, E1h–E6h, all others: 1.
  - 20h–3Fh (polygon): nv = bit27 ? 4 : 3; tex = bit26; gour = bit28. L = 1 + nv·(1+tex) + (gour ? nv−1 : 0). Maximum is 12.
  - 40h–5Fh (line): L = 3 + bit28. If bit27 is set, this is the polyline minimum.
  - 60h–7Fh (rect): L = 2 + bit26 + (bits[28:27]==0).
  - 80h–9Fh: 4. A0h–BFh: 3. C0h–DFh: 3.
- `FS_HEAD`:
  - `o_cmdReady` = !empty && count ≥ L.
  - On pop, load rem = L−1. Next state: A0h-class → `FS_CPY_HDR`; polyline → `FS_POLY` if rem==0, else `FS_PACKET` with a poly flag set; otherwise `FS_PACKET` if rem≠0, else stay in `FS_HEAD`.
- `FS_PACKET`:
  - `o_cmdReady` = 1 while !empty.
  - Each pop decrements rem. Popping the last word (rem==1) goes to `FS_HEAD`, or to `FS_POLY` if the poly flag is set.
- `FS_POLY`:
  - `o_cmdReady` = !empty.
  - `o_isTerminator` = !empty && (head & 5000_5000h) == 5000_5000h.
  - Popping a terminator → `FS_HEAD`.
- `FS_CPY_HDR`:
  - Popping the size word (rem==1) computes w = ((sz[15:0]−1)&3FFh)+1 and h = ((sz[31:16]−1)&1FFh)+1. A field value of 0 therefore gives 1024 and 512.
  - Loads rem = (w·h+1)>>1: 21-bit product, 19-bit result, maximum 262144.
  - Goes to `FS_CPY_DATA`.
- `FS_CPY_DATA`:
  - `o_dataPhase` = 1 and `o_cmdReady` = !empty.
  - Each pop decrements rem. Reaching 0 → `FS_HEAD`.
- Words arriving after a stream end are decoded as new commands.

## Timing
- Reset values: `o_empty`=1; `o_full`=0; `o_count`=0; `o_data`=0; `o_cmdReady`=0; `o_dataPhase`=0; `o_isTerminator`=0; state = `FS_HEAD`; rem=0.
- Write-to-visible latency is 1 cycle: a word pushed at edge n appears at the head and in `o_count` after edge n.
- `o_cmdReady`, `o_dataPhase` and `o_isTerminator` are combinational from the registered state, pointers and head word.
- A pop at edge n exposes the next word immediately after edge n.
- The w·h multiply occurs on the size-word pop and is registered. `o_dataPhase` rises the cycle after that pop.
- A pop when empty has no effect: no state change, no pointer move.

## Structure
- Add to `gpuPack`: the `fifoState_t` enum, `POLY_TERM_MASK`/`POLY_TERM_VALUE` = 32'h5000_5000, and `GP0_MAX_PACKET` = 12.
- Sub-module `gp0_cmd_length`: purely combinational. Maps opcode[31:24] → L[3:0] plus flags isPoly and isCpuToVram.

## Test plan
- Fill: push 02FF_0000h, 0010_0020h, 0008_0010h → `o_cmdReady` low after words 1–2, high after word 3. Three pops → `FS_HEAD`, empty.
- Quad: push 3Ch with gouraud, textured and quad set, plus 11 words → `o_cmdReady` stays 0 until the 12th word is written, then becomes 1.
- CPU→VRAM: push A000_0000h, 0000_0000h, 0003_0003h, six data words → `o_dataPhase` rises after the 3rd pop. Exactly 5 data pops follow, then `FS_HEAD`; the 6th data word is decoded as a command.
- Polyline: push 4800_00FFh, 3 XY words, 5555_5555h → `o_isTerminator` high only when 5555_5555h is at the head. Popping it → `FS_HEAD`.
- Overflow: 17 pushes, no pops → `o_full`=1 after the 16th push, the 17th push is dropped, count=16. A simultaneous push and pop while full keeps count=16.
- Flush mid-stream: in `FS_CPY_DATA` with rem=100, assert `i_flush` → next cycle count=0, `o_dataPhase`=0, state = `FS_HEAD`. Size 0000_0000h gives rem=262144.
